// File: rtl/dut_seq_pkg.sv
// ------------------------------------------------------------------
// dut_seq_pkg : opcodes, FSM encoding and width helper for the sequencer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package dut_seq_pkg;

  localparam logic [7:0] C_OP_NOP         = 8'h00;
  localparam logic [7:0] C_OP_SETUP_MUXES = 8'h01;
  localparam logic [7:0] C_OP_STIM_BURST  = 8'h02;
  localparam logic [7:0] C_OP_SYNC        = 8'h03;
  localparam logic [7:0] C_OP_END         = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_STIM  = 3'd2,
    ST_SYNC  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  function automatic int dif_width(input int cmd_ext_width, input int stf_width);
    return cmd_ext_width + stf_width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dut_test_sequencer_tracker.sv
// ------------------------------------------------------------------
// seq_vec_tracker : issued/completed vector counters, outstanding window
// and spurious-result detection. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seq_vec_tracker
  import dut_seq_pkg::*;
#(
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 count_en,
  input  logic                 issue,
  input  logic                 strobe,
  output logic [CNT_WIDTH-1:0] vec_issued,
  output logic [CNT_WIDTH-1:0] vec_completed,
  output logic                 can_issue,
  output logic                 all_done,
  output logic                 spurious
);

  logic [CNT_WIDTH-1:0] r_issued;
  logic [CNT_WIDTH-1:0] r_completed;
  logic [CNT_WIDTH-1:0] w_outstanding;
  logic                 w_strobe_live;

  // Modulo difference keeps the window correct across counter wrap.
  assign w_outstanding = r_issued - r_completed;
  assign can_issue     = {1'b0, w_outstanding} < (CNT_WIDTH+1)'(MAX_OUTSTANDING);
  assign all_done      = (r_issued == r_completed);
  assign w_strobe_live = strobe & count_en;
  assign spurious      = w_strobe_live & all_done & ~issue;

  assign vec_issued    = r_issued;
  assign vec_completed = r_completed;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_issued    <= '0;
      r_completed <= '0;
    end else begin
      if (issue)
        r_issued <= r_issued + CNT_WIDTH'(1);
      if (w_strobe_live && (!all_done || issue))
        r_completed <= r_completed + CNT_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dut_test_sequencer.sv
// ------------------------------------------------------------------
// dut_test_sequencer : runs a test program from the command FIFO into
// DI_FIFO / STIM_FIFO. Macro DUT_SEQ_TIMEOUT_EN adds a SYNC watchdog. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module dut_test_sequencer
  import dut_seq_pkg::*;
#(
  parameter int STF_WIDTH       = 24,
  parameter int CMD_EXT_WIDTH   = 8,
  parameter int DIF_WIDTH       = dif_width(CMD_EXT_WIDTH, STF_WIDTH),
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [DIF_WIDTH-1:0] cfifo_data,
  input  logic                 cfifo_rdempty,
  output logic                 cfifo_rdreq,
  output logic [STF_WIDTH-1:0] sfifo_data,
  output logic                 sfifo_wrreq,
  input  logic                 sfifo_wrfull,
  output logic [DIF_WIDTH-1:0] dififo_data,
  output logic                 dififo_wrreq,
  input  logic                 dififo_wrfull,
  input  logic                 res_strobe,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] vec_issued,
  output logic [CNT_WIDTH-1:0] vec_completed
);

  localparam logic [CMD_EXT_WIDTH-1:0] OPC_NOP   = CMD_EXT_WIDTH'(C_OP_NOP);
  localparam logic [CMD_EXT_WIDTH-1:0] OPC_SETUP = CMD_EXT_WIDTH'(C_OP_SETUP_MUXES);
  localparam logic [CMD_EXT_WIDTH-1:0] OPC_BURST = CMD_EXT_WIDTH'(C_OP_STIM_BURST);
  localparam logic [CMD_EXT_WIDTH-1:0] OPC_SYNC  = CMD_EXT_WIDTH'(C_OP_SYNC);
  localparam logic [CMD_EXT_WIDTH-1:0] OPC_END   = CMD_EXT_WIDTH'(C_OP_END);

  seq_state_t               r_state;
  logic [CNT_WIDTH-1:0]     r_remaining;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [CMD_EXT_WIDTH-1:0] w_opcode;
  logic [CNT_WIDTH-1:0]     w_burst_len;
  logic                     w_fetch_go;
  logic                     w_fetch_pop;
  logic                     w_di_write;
  logic                     w_stim_write;
  logic                     w_can_issue;
  logic                     w_all_done;
  logic                     w_spurious;
  logic                     w_timeout;

  assign w_opcode    = cfifo_data[DIF_WIDTH-1 -: CMD_EXT_WIDTH];
  assign w_burst_len = cfifo_data[CNT_WIDTH-1:0];

  // A SETUP_MUXES word is only consumed when DI_FIFO can take it.
  assign w_fetch_go   = (r_state == ST_FETCH) && !cfifo_rdempty;
  assign w_di_write   = w_fetch_go && (w_opcode == OPC_SETUP) && !dififo_wrfull;
  assign w_fetch_pop  = w_fetch_go && ((w_opcode != OPC_SETUP) || !dififo_wrfull);
  assign w_stim_write = (r_state == ST_STIM) && !cfifo_rdempty && !sfifo_wrfull && w_can_issue;

  assign cfifo_rdreq  = w_fetch_pop | w_stim_write;
  assign dififo_wrreq = w_di_write;
  assign dififo_data  = cfifo_data;
  assign sfifo_wrreq  = w_stim_write;
  assign sfifo_data   = cfifo_data[STF_WIDTH-1:0];

  assign busy  = r_busy;
  assign done  = r_done;
  assign error = r_error;

  seq_vec_tracker #(
    .CNT_WIDTH       (CNT_WIDTH),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tracker (
    .clock         (clock),
    .reset         (reset),
    .clear         ((r_state == ST_IDLE) && start),
    .count_en      (r_state != ST_IDLE),
    .issue         (w_stim_write),
    .strobe        (res_strobe),
    .vec_issued    (vec_issued),
    .vec_completed (vec_completed),
    .can_issue     (w_can_issue),
    .all_done      (w_all_done),
    .spurious      (w_spurious)
  );

`ifdef DUT_SEQ_TIMEOUT_EN
  logic [31:0] r_wdog;

  // Held at zero outside SYNC, so every SYNC entry starts a fresh count.
  always_ff @(posedge clock) begin
    if (reset || (r_state != ST_SYNC))
      r_wdog <= '0;
    else
      r_wdog <= r_wdog + 32'd1;
  end

  assign w_timeout = (r_state == ST_SYNC) && (r_wdog == 32'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_spurious)
        r_error <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (w_fetch_pop) begin
            case (w_opcode)
              OPC_NOP, OPC_SETUP: begin
              end
              OPC_BURST: begin
                r_remaining <= w_burst_len;
                if (w_burst_len != '0)
                  r_state <= ST_STIM;
              end
              OPC_SYNC: r_state <= ST_SYNC;
              OPC_END: begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
              default: r_error <= 1'b1;
            endcase
          end
        end
        ST_STIM: begin
          if (w_stim_write) begin
            r_remaining <= r_remaining - CNT_WIDTH'(1);
            if (r_remaining == CNT_WIDTH'(1))
              r_state <= ST_FETCH;
          end
        end
        ST_SYNC: begin
          if (w_all_done) begin
            r_state <= ST_FETCH;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
